// File: rtl/scan_config_loader.sv
// Host-side loader for the clb/conn configuration scan chains: serialises host
// words LSB-first onto the selected chain and returns the captured chain bits.
module scan_config_loader #(
    parameter int WORD_W         = 8,
    parameter int CLB_CHAIN_LEN  = 16,
    parameter int CONN_CHAIN_LEN = 64,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              chain_sel,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              scan_clk,
    output logic              clb_scan_en,
    output logic              clb_scan_in,
    input  logic              clb_scan_out,
    output logic              conn_scan_en,
    output logic              conn_scan_in,
    input  logic              conn_scan_out,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CLB_LAST  = CNT_W'(CLB_CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CONN_LAST = CNT_W'(CONN_CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SH_LO = 3'd2,
        SH_HI = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_r;
    logic               sel_r;
    logic               pend_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WORD_W-1:0]  sh_r;
    logic [WORD_W-1:0]  rb_r;

    logic               slot_free_s;
    logic               scan_bit_s;
    logic               last_bit_s;
    logic [WORD_W-1:0]  sh_next_s;

    // Output-slot availability, returning chain bit and end-of-chain detect.
    always_comb begin
        slot_free_s = !dout_valid || dout_ready;
        sh_next_s   = sh_r >> 1;
        if (sel_r) begin
            scan_bit_s = conn_scan_out;
            last_bit_s = (cnt_r == CONN_LAST);
        end else begin
            scan_bit_s = clb_scan_out;
            last_bit_s = (cnt_r == CLB_LAST);
        end
    end

    // Loader FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            sel_r        <= 1'b0;
            pend_r       <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            sh_r         <= {WORD_W{1'b0}};
            rb_r         <= {WORD_W{1'b0}};
            din_ready    <= 1'b0;
            dout         <= {WORD_W{1'b0}};
            dout_valid   <= 1'b0;
            scan_clk     <= 1'b0;
            clb_scan_en  <= 1'b0;
            clb_scan_in  <= 1'b0;
            conn_scan_en <= 1'b0;
            conn_scan_in <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sel_r        <= chain_sel;
                        cnt_r        <= {CNT_W{1'b0}};
                        idx_r        <= {IDX_W{1'b0}};
                        rb_r         <= {WORD_W{1'b0}};
                        pend_r       <= 1'b0;
                        busy         <= 1'b1;
                        clb_scan_en  <= !chain_sel;
                        conn_scan_en <= chain_sel;
                        din_ready    <= 1'b1;
                        state_r      <= FETCH;
                    end
                end
                FETCH: begin
                    // A held-back readback word must leave before new data enters.
                    if (pend_r) begin
                        if (slot_free_s) begin
                            dout       <= rb_r;
                            dout_valid <= 1'b1;
                            rb_r       <= {WORD_W{1'b0}};
                            pend_r     <= 1'b0;
                            din_ready  <= 1'b1;
                        end
                    end else if (din_valid && din_ready) begin
                        sh_r      <= din;
                        din_ready <= 1'b0;
                        scan_clk  <= 1'b0;
                        if (sel_r) begin
                            conn_scan_in <= din[0];
                        end else begin
                            clb_scan_in <= din[0];
                        end
                        state_r <= SH_LO;
                    end
                end
                SH_LO: begin
                    rb_r[idx_r] <= scan_bit_s;
                    scan_clk    <= 1'b1;
                    state_r     <= SH_HI;
                end
                SH_HI: begin
                    scan_clk <= 1'b0;
                    if (last_bit_s || (idx_r == IDX_LAST)) begin
                        if (slot_free_s) begin
                            dout       <= rb_r;
                            dout_valid <= 1'b1;
                            rb_r       <= {WORD_W{1'b0}};
                            pend_r     <= 1'b0;
                        end else begin
                            pend_r <= 1'b1;
                        end
                        if (last_bit_s) begin
                            state_r <= FLUSH;
                        end else begin
                            cnt_r     <= cnt_r + CNT_W'(1);
                            idx_r     <= {IDX_W{1'b0}};
                            din_ready <= slot_free_s;
                            state_r   <= FETCH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        idx_r <= idx_r + IDX_W'(1);
                        sh_r  <= sh_next_s;
                        if (sel_r) begin
                            conn_scan_in <= sh_next_s[0];
                        end else begin
                            clb_scan_in <= sh_next_s[0];
                        end
                        state_r <= SH_LO;
                    end
                end
                FLUSH: begin
                    if (pend_r) begin
                        if (slot_free_s) begin
                            dout       <= rb_r;
                            dout_valid <= 1'b1;
                            rb_r       <= {WORD_W{1'b0}};
                            pend_r     <= 1'b0;
                        end
                    end else if (dout_valid && dout_ready) begin
                        clb_scan_en  <= 1'b0;
                        conn_scan_en <= 1'b0;
                        clb_scan_in  <= 1'b0;
                        conn_scan_in <= 1'b0;
                        done         <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/scan_config_loader.md
Name: scan_config_loader

Overview:
- Host-side driver for the fabric configuration scan chains. It is the transmitting end of the clb_scan and conn_scan chains that run through the tile array.
- It accepts configuration words from the host over a valid/ready stream and serialises them LSB-first onto the selected chain. It also generates scan_clk and the chain's scan enable.
- At the same time it captures the bits emerging from the chain's scan_out and returns them to the host as readback words.

Parameters:
WORD_W, 8, width of host data and readback words
CLB_CHAIN_LEN, 16, bits in the clb scan chain
CONN_CHAIN_LEN, 64, bits in the conn scan chain
CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > max chain length

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to load a chain; ignored while busy
chain_sel  in  1  0 = clb chain, 1 = conn chain; sampled when start is accepted
din  in  WORD_W  configuration word, LSB shifted first
din_valid  in  1  din is valid
din_ready  out  1  loader accepts din this cycle
dout  out  WORD_W  readback word, first-captured bit in LSB
dout_valid  out  1  dout holds a word; held until accepted
dout_ready  in  1  host accepts dout
scan_clk  out  1  scan clock to the fabric, registered
clb_scan_en  out  1  clb chain shift enable
clb_scan_in  out  1  serial data into the clb chain
clb_scan_out  in  1  serial data from the clb chain
conn_scan_en  out  1  conn chain shift enable
conn_scan_in  out  1  serial data into the conn chain
conn_scan_out  in  1  serial data from the conn chain
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the load completes

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, including dout (all zeros); state = IDLE. Reset mid-load aborts the load immediately: scan_clk, both scan enables and both scan_in lines drop to 0 and any partial words are discarded.
- States: IDLE, FETCH, SH_LO, SH_HI, FLUSH, DONE.
- IDLE:
  - start=1 latches chain_sel, clears the bit counter and bit-in-word index, sets busy, and goes to FETCH.
  - The selected chain's scan_en goes high on the next cycle and stays high until leaving FLUSH.
- FETCH:
  - din_ready=1 while in FETCH, unless an untaken readback word is pending (dout_valid=1 and no dout_ready).
  - On din_valid && din_ready, the word is loaded into the shift register and the state goes to SH_LO.
- SH_LO (one clk):
  - scan_clk=0.
  - The selected scan_in is driven with the current shift-register LSB.
  - The non-selected scan_in stays 0.
- SH_HI (one clk):
  - scan_clk=1; the fabric captures on this rising edge.
  - On the edge that raises scan_clk, the selected scan_out is sampled; this is its pre-shift value. The sample goes into the readback register at the bit-in-word index.
  - Each bit therefore takes 2 clk cycles.
- After SH_HI, if the bit counter reaches LEN-1 (LEN = CLB_CHAIN_LEN or CONN_CHAIN_LEN per the latched select), go to FLUSH. Otherwise:
  - Increment the counters.
  - If the word is exhausted (index = WORD_W-1), the readback word is pushed to dout and the state goes to FETCH.
  - Otherwise, shift and go to SH_LO.
- Readback stall: if a new readback word is ready while dout_valid is still 1 and dout_ready is 0, the loader waits in FETCH and does not toggle scan_clk until the previous word is accepted. No readback data is ever dropped.
- Final word:
  - When LEN is not a multiple of WORD_W, the final din word's upper bits are ignored.
  - The final readback word is zero-padded above the last captured bit.
  - Total din words = total dout words = ceil(LEN/WORD_W).
- FLUSH: push the final readback word. Once it is accepted (dout_valid && dout_ready), drop scan_en, keep scan_clk=0, and go to DONE.
- DONE: done=1 for one cycle, busy falls, then IDLE.
- Handshake rules:
  - dout/dout_valid are stable while dout_valid=1 and dout_ready=0.
  - A transfer occurs on the cycle where both valid and ready are high.
  - Simultaneous accept-and-new-push in one cycle is allowed.
- Data-path rules:
  - din is ignored outside FETCH.
  - start is ignored while busy=1.
  - chain_sel changes after acceptance have no effect.
  - The non-selected chain's scan_en and scan_in stay 0 throughout.

Test Plan:
- Reset then idle -> all outputs 0, din_ready=0, scan_clk static low for 20 cycles.
- CLB load, LEN=16: start, chain_sel=0, din=0xA5 then 0x3C, dout_ready=1 -> clb_scan_in sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; exactly 16 scan_clk rising edges; conn_scan_en stays 0; done pulses once.
- Loopback readback: model the fabric as a 16-bit shift register preloaded with 0x1234, load 0xFFFF -> dout = 0x34 then 0x12; the model then holds 0xFFFF.
- Partial word with CONN_CHAIN_LEN overridden to 12: 2 din words (0xFF, 0x0F); the din upper nibble is ignored -> 12 edges; second dout has bits [7:4]=0.
- Backpressure: hold dout_ready=0 after the first readback word -> scan_clk stops, din_ready=0; release -> loading resumes with no lost or duplicated bits.
- Reset asserted mid-SH_HI -> scan_clk, clb_scan_en, busy and dout_valid all 0 immediately; a new start then loads correctly from bit 0.
